// File: rtl/exp_norm_adjust_m.sv
// Exponent post-processing for the FP multiplier: adds normalisation and rounding increments,
// saturates to infinity/zero exponent and flags it. Optional sticky flags: EXP_STICKY_FLAGS_EN.
module exp_norm_adjust_m #(
    parameter int W_Exp = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_Exp:0]   exp_pr,
    input  logic             exp_ufl_in,
    input  logic             norm_bit,
    input  logic             rnd_valid,
    input  logic             rnd_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_Exp-1:0] exp_final,
    output logic             ovf_flag,
`ifdef EXP_STICKY_FLAGS_EN
    output logic             ufl_flag,
    input  logic             clr_flags
`else
    output logic             ufl_flag
`endif
);

    localparam int W_S = W_Exp + 2;
    localparam logic [W_Exp-1:0]      EXP_MAX   = {W_Exp{1'b1}};
    localparam logic signed [W_S-1:0] EXP_MAX_S = $signed({2'b00, EXP_MAX});
    localparam logic signed [W_S-1:0] ZERO_S    = {W_S{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_NORM     = 3'd1,
        ST_WAIT_RND = 3'd2,
        ST_CHECK    = 3'd3,
        ST_OUT      = 3'd4
    } state_t;

    state_t                  state_r, state_next_s;
    logic signed [W_S-1:0]   s_r, s_next_s;
    logic                    norm_r, norm_next_s;
    logic                    out_valid_r, out_valid_next_s;
    logic [W_Exp-1:0]        exp_final_r, exp_next_s;
    logic                    ovf_r, ovf_next_s;
    logic                    ufl_r, ufl_next_s;
    logic                    in_ready_r;
    logic                    chk_en_s, chk_ovf_s, chk_ufl_s;

    // Next-state, exponent accumulation and range check
    always_comb begin
        state_next_s     = state_r;
        s_next_s         = s_r;
        norm_next_s      = norm_r;
        out_valid_next_s = out_valid_r;
        exp_next_s       = exp_final_r;
        chk_en_s         = 1'b0;
        chk_ovf_s        = 1'b0;
        chk_ufl_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    s_next_s     = $signed({exp_ufl_in, exp_pr});
                    norm_next_s  = norm_bit;
                    state_next_s = ST_NORM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_NORM: begin
                s_next_s     = s_r + $signed({{(W_S-1){1'b0}}, norm_r});
                state_next_s = ST_WAIT_RND;
            end
            ST_WAIT_RND: begin
                if (rnd_valid) begin
                    s_next_s     = s_r + $signed({{(W_S-1){1'b0}}, rnd_carry});
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = ST_WAIT_RND;
                end
            end
            ST_CHECK: begin
                chk_en_s = 1'b1;
                // s is two's complement, so a borrowed exponent compares below zero
                if (s_r >= EXP_MAX_S) begin
                    exp_next_s = EXP_MAX;
                    chk_ovf_s  = 1'b1;
                end else if (s_r <= ZERO_S) begin
                    exp_next_s = {W_Exp{1'b0}};
                    chk_ufl_s  = 1'b1;
                end else begin
                    exp_next_s = s_r[W_Exp-1:0];
                end
                out_valid_next_s = 1'b1;
                state_next_s     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_next_s = 1'b0;
                    state_next_s     = ST_IDLE;
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            default: begin
                out_valid_next_s = 1'b0;
                state_next_s     = ST_IDLE;
            end
        endcase
    end

    // Flag update: a CHECK in the same cycle as a clear keeps its own flags
    always_comb begin
        ovf_next_s = ovf_r;
        ufl_next_s = ufl_r;
`ifdef EXP_STICKY_FLAGS_EN
        if (chk_en_s) begin
            ovf_next_s = clr_flags ? chk_ovf_s : (ovf_r | chk_ovf_s);
            ufl_next_s = clr_flags ? chk_ufl_s : (ufl_r | chk_ufl_s);
        end else if (clr_flags) begin
            ovf_next_s = 1'b0;
            ufl_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
            ufl_next_s = ufl_r;
        end
`else
        if (chk_en_s) begin
            ovf_next_s = chk_ovf_s;
            ufl_next_s = chk_ufl_s;
        end else begin
            ovf_next_s = ovf_r;
            ufl_next_s = ufl_r;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            s_r         <= {W_S{1'b0}};
            norm_r      <= 1'b0;
            out_valid_r <= 1'b0;
            exp_final_r <= {W_Exp{1'b0}};
            ovf_r       <= 1'b0;
            ufl_r       <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            s_r         <= s_next_s;
            norm_r      <= norm_next_s;
            out_valid_r <= out_valid_next_s;
            exp_final_r <= exp_next_s;
            ovf_r       <= ovf_next_s;
            ufl_r       <= ufl_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign exp_final = exp_final_r;
    assign ovf_flag  = ovf_r;
    assign ufl_flag  = ufl_r;

endmodule
